// File: rtl/fb_pkg.sv
// Shared types and default geometry for the double frame buffer.
package fb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR     = 2'd1,
    SWAP_WAIT = 2'd2
  } fb_state_e;

  localparam int DEF_H_RES   = 640;
  localparam int DEF_V_RES   = 480;
  localparam int DEF_IDX_W   = 5;
  localparam int DEF_OUT_W   = 8;
  localparam int DEF_COORD_W = 11;

  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/double_frame_buffer_if.sv
// Draw, scan-out and control signals of the double frame buffer.
interface double_frame_buffer_if #(
  parameter int COORD_W = fb_pkg::DEF_COORD_W,
  parameter int OUT_W   = fb_pkg::DEF_OUT_W
);
  logic               We;
  logic [COORD_W-1:0] AddrX;
  logic [COORD_W-1:0] AddrY;
  logic [OUT_W-1:0]   ColorIdxIn;
  logic [OUT_W-1:0]   Color_Filter;
  logic [COORD_W-1:0] Read_AddrX;
  logic [COORD_W-1:0] Read_AddrY;
  logic [OUT_W-1:0]   ColorIdxOut;
  logic               Frame_Start;
  logic               Swap_Req;
  logic               Clear_Req;
  logic               Front_Sel;
  logic               Swap_Pending;
  logic               Clear_Busy;
  logic               Wr_Ready;

  modport master (
    output We, AddrX, AddrY, ColorIdxIn, Color_Filter, Read_AddrX, Read_AddrY,
           Frame_Start, Swap_Req, Clear_Req,
    input  ColorIdxOut, Front_Sel, Swap_Pending, Clear_Busy, Wr_Ready
  );

  modport slave (
    input  We, AddrX, AddrY, ColorIdxIn, Color_Filter, Read_AddrX, Read_AddrY,
           Frame_Start, Swap_Req, Clear_Req,
    output ColorIdxOut, Front_Sel, Swap_Pending, Clear_Busy, Wr_Ready
  );
endinterface

// File: rtl/fb_bank.sv
// One frame bank: single write port, single read port with registered data.
module fb_bank #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 5
) (
  input  logic              Clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rd_data_r;

  // Storage write and one-cycle read; contents are deliberately not reset
  always_ff @(posedge Clk) begin
    if (we) begin
      mem_r[wr_addr] <= wr_data;
    end
    rd_data_r <= mem_r[rd_addr];
  end

  assign rd_data = rd_data_r;
endmodule

// File: rtl/double_frame_buffer.sv
// Double-buffered palette frame store with swap-on-vblank and optional clear
// engine (enabled by defining DFB_CLEAR_EN).
module double_frame_buffer
  import fb_pkg::*;
#(
  parameter int H_RES     = DEF_H_RES,
  parameter int V_RES     = DEF_V_RES,
  parameter int IDX_W     = DEF_IDX_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int COORD_W   = DEF_COORD_W,
  parameter int CLEAR_IDX = 0
) (
  input logic                  Clk,
  input logic                  Reset_n,
  double_frame_buffer_if.slave bus
);
  localparam int DEPTH  = H_RES * V_RES;
  localparam int ADDR_W = addr_bits(DEPTH);
  localparam logic [IDX_W-1:0] CLR_VAL = IDX_W'(CLEAR_IDX);

  fb_state_e         state_r;
  logic              front_sel_r, swap_pend_r, wr_ready_r, rd_valid_r, rd_sel_r;
  logic              wr_in_range_s, rd_in_range_s, draw_we_s, bank_we_s;
  logic              clr_we_s, clr_last_s, clear_req_s;
  logic [ADDR_W-1:0] draw_addr_s, rd_lin_s, rd_addr_s, clr_addr_s, wr_addr_s;
  logic [IDX_W-1:0]  wr_data_s, rd_data0_s, rd_data1_s;

  // Bounds are checked on the full coordinates before any address narrowing
  assign wr_in_range_s = (32'(bus.AddrX) < 32'(H_RES)) && (32'(bus.AddrY) < 32'(V_RES));
  assign rd_in_range_s = (32'(bus.Read_AddrX) < 32'(H_RES)) && (32'(bus.Read_AddrY) < 32'(V_RES));
  assign draw_addr_s   = ADDR_W'(bus.AddrY) * ADDR_W'(H_RES) + ADDR_W'(bus.AddrX);
  assign rd_lin_s      = ADDR_W'(bus.Read_AddrY) * ADDR_W'(H_RES) + ADDR_W'(bus.Read_AddrX);

`ifdef DFB_CLEAR_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  logic [ADDR_W-1:0] clr_cnt_r;
  logic              clear_busy_r;

  assign clear_req_s    = bus.Clear_Req;
  assign clr_we_s       = (state_r == CLEAR);
  assign clr_last_s     = (clr_cnt_r == LAST_ADDR);
  assign clr_addr_s     = clr_cnt_r;
  assign bus.Clear_Busy = clear_busy_r;

  // Clear address sweep; busy mirrors the CLEAR state cycle for cycle
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      clr_cnt_r    <= {ADDR_W{1'b0}};
      clear_busy_r <= 1'b0;
    end else if ((state_r == IDLE) && clear_req_s) begin
      clr_cnt_r    <= {ADDR_W{1'b0}};
      clear_busy_r <= 1'b1;
    end else if (state_r == CLEAR) begin
      clr_cnt_r    <= clr_last_s ? {ADDR_W{1'b0}} : clr_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      clear_busy_r <= !clr_last_s;
    end else begin
      clr_cnt_r    <= clr_cnt_r;
      clear_busy_r <= 1'b0;
    end
  end
`else
  assign clear_req_s    = 1'b0;
  assign clr_we_s       = 1'b0;
  assign clr_last_s     = 1'b1;
  assign clr_addr_s     = {ADDR_W{1'b0}};
  assign bus.Clear_Busy = 1'b0;
`endif

  // Write-port arbitration between the clear engine and drawing
  always_comb begin
    draw_we_s = bus.We && (state_r == IDLE) && (bus.ColorIdxIn != bus.Color_Filter) && wr_in_range_s;
    if (clr_we_s) begin
      wr_addr_s = clr_addr_s;
      wr_data_s = CLR_VAL;
    end else begin
      wr_addr_s = draw_addr_s;
      wr_data_s = bus.ColorIdxIn[IDX_W-1:0];
    end
    if (rd_in_range_s) begin
      rd_addr_s = rd_lin_s;
    end else begin
      rd_addr_s = {ADDR_W{1'b0}};
    end
    bank_we_s = draw_we_s || clr_we_s;
  end

  fb_bank #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(IDX_W)) u_bank0 (
    .Clk(Clk), .we(bank_we_s && front_sel_r), .wr_addr(wr_addr_s), .wr_data(wr_data_s),
    .rd_addr(rd_addr_s), .rd_data(rd_data0_s)
  );

  fb_bank #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(IDX_W)) u_bank1 (
    .Clk(Clk), .we(bank_we_s && !front_sel_r), .wr_addr(wr_addr_s), .wr_data(wr_data_s),
    .rd_addr(rd_addr_s), .rd_data(rd_data1_s)
  );

  // Controller: clear sequencing and swap synchronised to Frame_Start
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_r     <= IDLE;
      front_sel_r <= 1'b0;
      swap_pend_r <= 1'b0;
      wr_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (clear_req_s) begin
            state_r     <= CLEAR;
            swap_pend_r <= bus.Swap_Req;
            wr_ready_r  <= 1'b0;
          end else if (bus.Swap_Req && bus.Frame_Start) begin
            front_sel_r <= !front_sel_r;
          end else if (bus.Swap_Req) begin
            state_r     <= SWAP_WAIT;
            swap_pend_r <= 1'b1;
            wr_ready_r  <= 1'b0;
          end
        end
        CLEAR: begin
          if (clr_last_s && (swap_pend_r || bus.Swap_Req)) begin
            state_r     <= SWAP_WAIT;
            swap_pend_r <= 1'b1;
          end else if (clr_last_s) begin
            state_r    <= IDLE;
            wr_ready_r <= 1'b1;
          end else begin
            swap_pend_r <= swap_pend_r || bus.Swap_Req;
          end
        end
        SWAP_WAIT: begin
          if (bus.Frame_Start) begin
            state_r     <= IDLE;
            front_sel_r <= !front_sel_r;
            swap_pend_r <= 1'b0;
            wr_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          swap_pend_r <= 1'b0;
          wr_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  // Read-side qualifiers aligned with the registered bank data
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rd_valid_r <= 1'b0;
      rd_sel_r   <= 1'b0;
    end else begin
      rd_valid_r <= rd_in_range_s;
      rd_sel_r   <= front_sel_r;
    end
  end

  assign bus.ColorIdxOut  = !rd_valid_r ? {OUT_W{1'b0}} :
                            rd_sel_r    ? OUT_W'(rd_data1_s) : OUT_W'(rd_data0_s);
  assign bus.Front_Sel    = front_sel_r;
  assign bus.Swap_Pending = swap_pend_r;
  assign bus.Wr_Ready     = wr_ready_r;
endmodule
